unidade_controle_jogo: RTL

Moore-type control unit for the sequence-memory game datapath. It sequences the address counter, the round counter, the play register and the comparator through progressive rounds. Each round replays the stored sequence one play longer than the last. The block enforces a per-play timeout and reports hit, miss or timeout. It sits between the top-level game circuit (iniciar, edge-detected switch plays) and the datapath.

---
 rtl/unidade_controle_jogo.sv | 116 +++++++++++
 1 files changed

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - Moore control unit sequencing the sequence-memory game datapath
//
// Ports:
//   clock_i           system clock, rising edge
//   reset_i           asynchronous active-high reset, forces INICIAL
//   iniciar_i         start request (level), honoured in INICIAL and end states
//   jogada_i          one-cycle play pulse, honoured only in ESPERA
//   igual_i           play register matches memory word at current address
//   fim_endereco_i    address counter reached round counter
//   fim_rodada_i      round counter reached last round
//   zera_endereco_o   clear address counter
//   conta_endereco_o  increment address counter
//   zera_rodada_o     clear round counter
//   conta_rodada_o    increment round counter
//   zera_registro_o   clear play register
//   registra_o        load play register
//   pronto_o          game over (any outcome)
//   acertou_o         game won
//   errou_o           wrong play
//   timeout_o         play not made in time
//   db_estado_o       current state code
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       iniciar_i,
  input  logic       jogada_i,
  input  logic       igual_i,
  input  logic       fim_endereco_i,
  input  logic       fim_rodada_i,
  output logic       zera_endereco_o,
  output logic       conta_endereco_o,
  output logic       zera_rodada_o,
  output logic       conta_rodada_o,
  output logic       zera_registro_o,
  output logic       registra_o,
  output logic       pronto_o,
  output logic       acertou_o,
  output logic       errou_o,
  output logic       timeout_o,
  output logic [3:0] db_estado_o
);

  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARA     = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARA     = 4'h5;
  localparam logic [3:0] PROX_JOGADA = 4'h6;
  localparam logic [3:0] PROX_RODADA = 4'h7;
  localparam logic [3:0] FIM_ACERTO  = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] FIM_ERRO    = 4'hE;

  // Last timer value allowed in ESPERA; reaching it ends the wait.
  localparam logic [11:0] TIMER_FIM = 12'(TIMEOUT_CICLOS - 1);

  logic [3:0]  estado_q, estado_d;
  logic [11:0] timer_q, timer_d;

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (iniciar_i) estado_d = PREPARA;
      PREPARA:     estado_d = ESPERA;
      ESPERA: begin
        // A play on the last allowed cycle still counts.
        if (jogada_i)                  estado_d = REGISTRA;
        else if (timer_q == TIMER_FIM) estado_d = FIM_TIMEOUT;
      end
      REGISTRA:    estado_d = COMPARA;
      COMPARA: begin
        if (!igual_i)             estado_d = FIM_ERRO;
        else if (!fim_endereco_i) estado_d = PROX_JOGADA;
        else if (!fim_rodada_i)   estado_d = PROX_RODADA;
        else                      estado_d = FIM_ACERTO;
      end
      PROX_JOGADA: estado_d = ESPERA;
      PROX_RODADA: estado_d = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar_i) estado_d = PREPARA;
      default:     estado_d = INICIAL;
    endcase
  end

  // Counting only while staying in ESPERA keeps the timer at zero on every
  // entry, so each wait gets the full window regardless of how the last ended.
  always_comb begin
    timer_d = '0;
    if (estado_q == ESPERA && estado_d == ESPERA) timer_d = timer_q + 12'd1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      estado_q <= INICIAL;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
    end
  end

  assign zera_endereco_o  = (estado_q == PREPARA) || (estado_q == PROX_RODADA);
  assign conta_endereco_o = (estado_q == PROX_JOGADA);
  assign zera_rodada_o    = (estado_q == PREPARA);
  assign conta_rodada_o   = (estado_q == PROX_RODADA);
  assign zera_registro_o  = (estado_q == PREPARA);
  assign registra_o       = (estado_q == REGISTRA);
  assign pronto_o         = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO) ||
                            (estado_q == FIM_TIMEOUT);
  assign acertou_o        = (estado_q == FIM_ACERTO);
  assign errou_o          = (estado_q == FIM_ERRO);
  assign timeout_o        = (estado_q == FIM_TIMEOUT);
  assign db_estado_o      = estado_q;

endmodule
